// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared types and constants for the shared-shifter arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_NOP = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

`default_nettype wire

// File: rtl/shift_word_fmt.sv
// ============================================================================
// shift_word_fmt : RV64 W-suffix operand preparation and result sign-extension
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_word_fmt #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               pre_word,
  input  logic [1:0]         pre_op,
  input  logic [DATA_W-1:0]  pre_data_in,
  input  logic [SHAMT_W-1:0] pre_amt_in,
  output logic [DATA_W-1:0]  pre_data,
  output logic [SHAMT_W-1:0] pre_amt,
  input  logic               post_word,
  input  logic [DATA_W-1:0]  post_in,
  output logic [DATA_W-1:0]  post_result
);

  logic [DATA_W-1:0] zext_lo;
  logic [DATA_W-1:0] sext_lo;

  assign zext_lo = {{(DATA_W-32){1'b0}}, pre_data_in[31:0]};
  assign sext_lo = {{(DATA_W-32){pre_data_in[31]}}, pre_data_in[31:0]};

  // Arithmetic and pass-through ops need the sign of the low word; logical ones must not see it.
  always_comb begin
    pre_data = pre_data_in;
    pre_amt  = pre_amt_in;
    if (pre_word) begin
      pre_data = pre_op[1] ? sext_lo : zext_lo;
      pre_amt  = {{(SHAMT_W-5){1'b0}}, pre_amt_in[4:0]};
    end
  end

  assign post_result = post_word ? {{(DATA_W-32){post_in[31]}}, post_in[31:0]} : post_in;

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// shift_arbiter : round-robin sharing of one barrel shifter between two ports
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_arbiter #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic [1:0]         op_a,
  input  logic               word_a,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [SHAMT_W-1:0] amt_a,
  input  logic               req_b,
  input  logic [1:0]         op_b,
  input  logic               word_b,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [SHAMT_W-1:0] amt_b,
  output logic               done_a,
  output logic               done_b,
  output logic [DATA_W-1:0]  result,
  output logic               busy,
  output logic [DATA_W-1:0]  sh_in,
  output logic [SHAMT_W-1:0] sh_num,
  output logic [1:0]         sh_op,
  input  logic [DATA_W-1:0]  sh_out
);

  import shift_pkg::*;

  arb_state_t         state;
  port_t              rr_last;
  port_t              owner;
  logic               word_q;

  logic               grant_a;
  logic               grant_b;
  port_t              win_port;
  logic [1:0]         win_op;
  logic               win_word;
  logic [DATA_W-1:0]  win_data;
  logic [SHAMT_W-1:0] win_amt;
  logic [DATA_W-1:0]  pre_data;
  logic [SHAMT_W-1:0] pre_amt;
  logic [DATA_W-1:0]  post_result;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_a  = req_a && (!req_b || (rr_last == PORT_B));
    grant_b  = req_b && !grant_a;
    win_port = grant_b ? PORT_B : PORT_A;
    win_op   = grant_b ? op_b   : op_a;
    win_word = grant_b ? word_b : word_a;
    win_data = grant_b ? data_b : data_a;
    win_amt  = grant_b ? amt_b  : amt_a;
  end

  shift_word_fmt #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_fmt (
    .pre_word    (win_word),
    .pre_op      (win_op),
    .pre_data_in (win_data),
    .pre_amt_in  (win_amt),
    .pre_data    (pre_data),
    .pre_amt     (pre_amt),
    .post_word   (word_q),
    .post_in     (sh_out),
    .post_result (post_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      sh_in   <= '0;
      sh_num  <= '0;
      sh_op   <= SH_NOP;
      rr_last <= PORT_B;
      word_q  <= 1'b0;
      owner   <= PORT_A;
    end else begin
      case (state)
        IDLE: begin
          done_a <= 1'b0;
          done_b <= 1'b0;
          if (grant_a || grant_b) begin
            sh_in   <= pre_data;
            sh_num  <= pre_amt;
            sh_op   <= win_op;
            word_q  <= win_word;
            owner   <= win_port;
            rr_last <= win_port;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          result <= post_result;
          done_a <= (owner == PORT_A);
          done_b <= (owner == PORT_B);
          state  <= RESP;
        end
        RESP: begin
          done_a <= 1'b0;
          done_b <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_a <= 1'b0;
          done_b <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
